vram_write_arbiter: RTL and testbench

- Owns the single write port of the 6144-byte video RAM. Shares it between CPU byte stores and a hardware fill engine that clears or fills screen regions.
- Sits between the CPU memory-mapped video window and the VGA top-level's vmem_in_addr/vmem_in_data/vmem_we inputs.
- Clocked by the 100 MHz system clock, the same clock as the video RAM.

---
 rtl/vram_write_arbiter_if.sv | 37 +++
 rtl/vram_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vram_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_write_arbiter_if.sv
// Bundle of the CPU store port, fill-engine control port and the registered
// video-RAM write port handled by vram_write_arbiter.
interface vram_write_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_data;
  logic              cpu_ready;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] fill_len;
  logic [7:0]        fill_value;
  logic              fill_abort;
  logic              fill_busy;
  logic              fill_done;

  logic [ADDR_W-1:0] vmem_addr;
  logic [7:0]        vmem_data;
  logic              vmem_we;

  // Requester side: CPU window, fill launcher and the video-RAM consumer.
  modport master (
    output cpu_valid, cpu_addr, cpu_data,
    output fill_start, fill_base, fill_len, fill_value, fill_abort,
    input  cpu_ready, fill_busy, fill_done,
    input  vmem_addr, vmem_data, vmem_we
  );

  modport slave (
    input  cpu_valid, cpu_addr, cpu_data,
    input  fill_start, fill_base, fill_len, fill_value, fill_abort,
    output cpu_ready, fill_busy, fill_done,
    output vmem_addr, vmem_data, vmem_we
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Shares the single video-RAM write port between CPU byte stores and a
// hardware fill engine; the CPU may win at most CPU_RUN_MAX cycles in a row.
module vram_write_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int VRAM_SIZE   = 6144,
  parameter int CPU_RUN_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  vram_write_arbiter_if.slave  bus
);

  localparam int                RUN_W     = $clog2(CPU_RUN_MAX + 1);
  localparam logic [ADDR_W-1:0] SIZE_A    = ADDR_W'(VRAM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_SIZE - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX_C = RUN_W'(CPU_RUN_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [RUN_W-1:0]  run_count;
  logic [ADDR_W-1:0] fill_addr;
  logic [ADDR_W-1:0] fill_remaining;
  logic [7:0]        fill_value_q;

  logic [ADDR_W-1:0] vmem_addr_q;
  logic [7:0]        vmem_data_q;
  logic              vmem_we_q;

  logic              cpu_grant;
  logic              fill_grant;
  logic              cpu_ready_c;
  logic              run_below_max;
  logic [ADDR_W-1:0] fill_addr_next;
  logic [ADDR_W-1:0] base_folded;

  assign run_below_max  = (run_count < RUN_MAX_C);
  assign fill_addr_next = (fill_addr == LAST_ADDR) ? '0 : fill_addr + ADDR_W'(1);
  // An out-of-range base is folded back once; any 13-bit base minus 6144 is in range.
  assign base_folded    = (bus.fill_base >= SIZE_A) ? bus.fill_base - SIZE_A
                                                    : bus.fill_base;

  // ---------------------------------------------------------------------------
  // Next-state and grant decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next  = state;
    cpu_grant   = 1'b0;
    fill_grant  = 1'b0;
    cpu_ready_c = 1'b0;

    case (state)
      IDLE: begin
        cpu_ready_c = 1'b1;
        cpu_grant   = bus.cpu_valid;
        if (bus.fill_start) begin
          state_next = (bus.fill_len == '0) ? DONE : FILL;
        end
      end

      FILL: begin
        cpu_grant   = bus.cpu_valid && run_below_max;
        fill_grant  = !cpu_grant;
        cpu_ready_c = cpu_grant;
        if (bus.fill_abort || (fill_grant && fill_remaining == ADDR_W'(1))) begin
          state_next = DONE;
        end
      end

      DONE: begin
        cpu_ready_c = 1'b1;
        cpu_grant   = bus.cpu_valid;
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and fill context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state          <= IDLE;
      run_count      <= '0;
      fill_addr      <= '0;
      fill_remaining <= '0;
      fill_value_q   <= '0;
    end else begin
      state <= state_next;

      if (state == FILL && cpu_grant) begin
        run_count <= run_count + RUN_W'(1);
      end else begin
        run_count <= '0;
      end

      if (state == IDLE && bus.fill_start) begin
        fill_addr      <= base_folded;
        fill_remaining <= bus.fill_len;
        fill_value_q   <= bus.fill_value;
      end else if (fill_grant) begin
        fill_addr      <= fill_addr_next;
        fill_remaining <= fill_remaining - ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered video-RAM write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: address and data are reset too, not just the strobe, because the
    // VGA top-level sees these registers directly and expects zeros in reset.
    if (!rst) begin
      vmem_addr_q <= '0;
      vmem_data_q <= '0;
      vmem_we_q   <= 1'b0;
    end else if (cpu_grant) begin
      vmem_addr_q <= bus.cpu_addr;
      vmem_data_q <= bus.cpu_data;
      vmem_we_q   <= (bus.cpu_addr < SIZE_A);
    end else if (fill_grant) begin
      vmem_addr_q <= fill_addr;
      vmem_data_q <= fill_value_q;
      vmem_we_q   <= 1'b1;
    end else begin
      vmem_we_q   <= 1'b0;
    end
  end

  // cpu_ready is gated by reset so the whole port reads zero while rst is low.
  assign bus.cpu_ready = rst && cpu_ready_c;
  assign bus.fill_busy = (state == FILL);
  assign bus.fill_done = (state == DONE);
  assign bus.vmem_addr = vmem_addr_q;
  assign bus.vmem_data = vmem_data_q;
  assign bus.vmem_we   = vmem_we_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_we_in_range: assert property (@(posedge clk) disable iff (!rst)
    bus.vmem_we |-> (bus.vmem_addr < SIZE_A));

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst)
    !(bus.fill_busy && bus.fill_done));

  a_run_bound: assert property (@(posedge clk) disable iff (!rst)
    (state == FILL) |-> (run_count <= RUN_MAX_C));

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every vmem_we cycle.
module tb_vram_write_arbiter;

  localparam int ADDR_W = 13;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  wr_t  exp_q[$];

  vram_write_arbiter_if #(.ADDR_W(ADDR_W)) vif ();

  vram_write_arbiter #(
    .ADDR_W      (ADDR_W),
    .VRAM_SIZE   (6144),
    .CPU_RUN_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (vif.vmem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected no write",
                 vif.vmem_addr, vif.vmem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write", {11'd0, vif.vmem_addr, vif.vmem_data}, {11'd0, e.addr, e.data});
      end
    end
  end

  initial begin
    int n;
    int fills;
    logic exp_ready;

    rst = 1'b0;
    vif.cpu_valid  = 1'b0;
    vif.cpu_addr   = '0;
    vif.cpu_data   = '0;
    vif.fill_start = 1'b0;
    vif.fill_base  = '0;
    vif.fill_len   = '0;
    vif.fill_value = '0;
    vif.fill_abort = 1'b0;

    // Reset state
    #2;
    check("rst_vmem_we",   vif.vmem_we,   0);
    check("rst_vmem_addr", vif.vmem_addr, 0);
    check("rst_vmem_data", vif.vmem_data, 0);
    check("rst_cpu_ready", vif.cpu_ready, 0);
    check("rst_fill_busy", vif.fill_busy, 0);
    check("rst_fill_done", vif.fill_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Single CPU store
    vif.cpu_valid = 1'b1;
    vif.cpu_addr  = 13'h0100;
    vif.cpu_data  = 8'h41;
    #1 check("t1_cpu_ready", vif.cpu_ready, 1);
    push(13'h0100, 8'h41);
    step();
    vif.cpu_valid = 1'b0;
    #1 check("t1_we_next_cycle", vif.vmem_we, 1);
    step();
    check("t1_we_one_cycle", vif.vmem_we, 0);

    // Wrapping fill: 6140..6143, 0, 1
    vif.fill_start = 1'b1;
    vif.fill_base  = 13'd6140;
    vif.fill_len   = 13'd6;
    vif.fill_value = 8'h20;
    for (int i = 0; i < 4; i++) push(13'(6140 + i), 8'h20);
    push(13'd0, 8'h20);
    push(13'd1, 8'h20);
    step();
    vif.fill_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 check("t2_busy", vif.fill_busy, 1);
      check("t2_no_done", vif.fill_done, 0);
      step();
    end
    check("t2_done", vif.fill_done, 1);
    check("t2_busy_low", vif.fill_busy, 0);
    check("t2_last_write", vif.vmem_we, 1);
    step();
    check("t2_done_once", vif.fill_done, 0);

    // Fill len 100 against continuous CPU traffic, started alongside a store
    n = 0;
    fills = 0;
    vif.fill_start = 1'b1;
    vif.fill_base  = 13'h0200;
    vif.fill_len   = 13'd100;
    vif.fill_value = 8'h55;
    vif.cpu_valid  = 1'b1;
    vif.cpu_addr   = 13'h1000;
    vif.cpu_data   = 8'h00;
    #1 check("t3_start_cpu_ready", vif.cpu_ready, 1);
    push(13'h1000, 8'h00);
    n = 1;
    step();
    vif.fill_start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      vif.cpu_addr = 13'(32'h1000 + n);
      vif.cpu_data = 8'(n);
      exp_ready = (k % 5) != 4;
      #1 check("t3_arb", vif.cpu_ready, exp_ready);
      if (exp_ready) begin
        push(13'(32'h1000 + n), 8'(n));
        n++;
      end else begin
        push(13'(32'h0200 + fills), 8'h55);
        fills++;
      end
      step();
    end
    vif.cpu_addr = 13'(32'h1000 + n);
    vif.cpu_data = 8'(n);
    #1 check("t3_done", vif.fill_done, 1);
    check("t3_busy_low", vif.fill_busy, 0);
    check("t3_done_cpu_ready", vif.cpu_ready, 1);
    push(13'(32'h1000 + n), 8'(n));
    step();
    vif.cpu_valid = 1'b0;
    #1 check("t3_done_once", vif.fill_done, 0);
    step();

    // Out-of-range CPU store, then zero-length fill
    vif.cpu_valid = 1'b1;
    vif.cpu_addr  = 13'd6144;
    vif.cpu_data  = 8'hEE;
    #1 check("t4_oor_ready", vif.cpu_ready, 1);
    step();
    vif.cpu_valid  = 1'b0;
    vif.fill_start = 1'b1;
    vif.fill_base  = 13'd0;
    vif.fill_len   = 13'd0;
    vif.fill_value = 8'h33;
    #1 check("t4_oor_no_we", vif.vmem_we, 0);
    step();
    vif.fill_start = 1'b0;
    #1 check("t4_len0_done", vif.fill_done, 1);
    check("t4_len0_busy", vif.fill_busy, 0);
    step();
    check("t4_len0_done_once", vif.fill_done, 0);
    check("t4_len0_no_we", vif.vmem_we, 0);

    // Abort after 10 fill writes; a second start mid-fill is ignored
    vif.fill_start = 1'b1;
    vif.fill_base  = 13'h0800;
    vif.fill_len   = 13'd50;
    vif.fill_value = 8'hAA;
    for (int i = 0; i < 10; i++) push(13'(32'h0800 + i), 8'hAA);
    step();
    for (int i = 0; i < 10; i++) begin
      vif.fill_start = (i == 4);
      vif.fill_base  = (i == 4) ? 13'h0000 : 13'h0800;
      vif.fill_len   = (i == 4) ? 13'd3 : 13'd50;
      vif.fill_value = (i == 4) ? 8'h11 : 8'hAA;
      #1 check("t5_busy", vif.fill_busy, 1);
      step();
    end
    vif.fill_start = 1'b0;
    vif.fill_abort = 1'b1;
    vif.cpu_valid  = 1'b1;
    vif.cpu_addr   = 13'h0123;
    vif.cpu_data   = 8'h5A;
    #1 check("t5_abort_cpu_ready", vif.cpu_ready, 1);
    push(13'h0123, 8'h5A);
    step();
    vif.fill_abort = 1'b0;
    vif.cpu_valid  = 1'b0;
    #1 check("t5_done", vif.fill_done, 1);
    check("t5_busy_low", vif.fill_busy, 0);
    step();
    check("t5_done_once", vif.fill_done, 0);
    check("t5_idle_busy", vif.fill_busy, 0);

    // Asynchronous reset mid-fill
    vif.fill_start = 1'b1;
    vif.fill_base  = 13'h0300;
    vif.fill_len   = 13'd20;
    vif.fill_value = 8'h77;
    for (int i = 0; i < 3; i++) push(13'(32'h0300 + i), 8'h77);
    step();
    vif.fill_start = 1'b0;
    step();
    step();
    step();
    #5 rst = 1'b0;
    #1 check("t6_rst_we",    vif.vmem_we,   0);
    check("t6_rst_addr",     vif.vmem_addr, 0);
    check("t6_rst_data",     vif.vmem_data, 0);
    check("t6_rst_ready",    vif.cpu_ready, 0);
    check("t6_rst_busy",     vif.fill_busy, 0);
    check("t6_rst_done",     vif.fill_done, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_done", vif.fill_done, 0);
      check("t6_idle", vif.fill_busy, 0);
    end
    vif.fill_start = 1'b1;
    vif.fill_base  = 13'h0010;
    vif.fill_len   = 13'd3;
    vif.fill_value = 8'h99;
    for (int i = 0; i < 3; i++) push(13'(32'h0010 + i), 8'h99);
    step();
    vif.fill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("t6_refill_busy", vif.fill_busy, 1);
      step();
    end
    check("t6_refill_done", vif.fill_done, 1);
    step();
    step();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
